// File: rtl/alu_seq.sv
// alu_seq: handshaked EX-stage ALU with registered results, an iterative
// divider and an iterative modular-exponentiation (DECRYPT) engine.
module alu_seq #(
  parameter int WIDTH    = 32,
  parameter int EXP_BITS = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4:0]       opcode,
  input  logic [WIDTH-1:0] rd,
  input  logic [WIDTH-1:0] rs,
  input  logic [WIDTH-1:0] rsi,
  input  logic [WIDTH-1:0] rt,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [4:0]       op_out,
  output logic [WIDTH-1:0] rd_out,
  output logic [WIDTH-1:0] rd_mem,
  output logic [WIDTH-1:0] alu_result,
  output logic [WIDTH-1:0] mem_result,
  output logic [WIDTH-1:0] mem_out,
  output logic [WIDTH-1:0] branch_result,
  output logic             wr_enable,
  output logic             mem_wr,
  output logic             mem_rd,
  output logic             err
);

  localparam int W  = WIDTH;
  localparam int SW = $clog2(WIDTH);
  localparam int CW = $clog2(2*WIDTH);
  localparam int KW = $clog2(2*EXP_BITS+2);
  localparam logic [KW-1:0] KLAST = KW'(2*EXP_BITS);
  localparam logic [CW-1:0] CRED  = CW'(2*WIDTH-1);
  localparam logic [CW-1:0] CDIV  = CW'(WIDTH-2);
  localparam logic [W-1:0]  WV    = W'(WIDTH);

  localparam logic [4:0] OP_NOP = 5'd0;
  localparam logic [4:0] OP_LV  = 5'd1;
  localparam logic [4:0] OP_MLT = 5'd2;
  localparam logic [4:0] OP_DIV = 5'd3;
  localparam logic [4:0] OP_SUB = 5'd4;
  localparam logic [4:0] OP_ADD = 5'd5;
  localparam logic [4:0] OP_CP  = 5'd6;
  localparam logic [4:0] OP_B   = 5'd7;
  localparam logic [4:0] OP_BEG = 5'd8;
  localparam logic [4:0] OP_SLL = 5'd9;
  localparam logic [4:0] OP_GP  = 5'd10;
  localparam logic [4:0] OP_DEC = 5'd12;

  typedef enum logic [2:0] {IDLE, DIV_RUN, MM_MUL, MM_RED, DONE} state_t;

  typedef struct packed {
    logic [4:0]   op;
    logic [W-1:0] rd_out;
    logic [W-1:0] rd_mem;
    logic [W-1:0] alu;
    logic [W-1:0] mres;
    logic [W-1:0] mout;
    logic [W-1:0] br;
    logic         we;
    logic         mw;
    logic         mr;
    logic         err;
  } res_t;

  state_t              state_q, state_d;
  res_t                out_q, out_d, sc;
  logic                ov_q, ov_d;
  logic [4:0]          opc_q, opc_d;
  logic [W-1:0]        rd_q, rd_d;
  logic [W-1:0]        rt_q, rt_d;
  logic [EXP_BITS-1:0] exp_q, exp_d;
  logic [W-1:0]        base_q, base_d;
  logic [W-1:0]        acc_q, acc_d;
  logic [2*W-1:0]      prod_q, prod_d;
  logic [W:0]          rem_q, rem_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [KW-1:0]       k_q, k_d;
  logic                dz_q, dz_d;
  logic [3*W:0]        st, st0;
  logic                accept;

  // Shared restoring step: shift the product MSB into the remainder,
  // trial-subtract, and shift the quotient bit into the product LSB.
  function automatic logic [3*W:0] step(input logic [W:0]     r,
                                        input logic [2*W-1:0] p,
                                        input logic [W-1:0]   d);
    logic [W:0] t;
    logic       q;
    t = {r[W-1:0], p[2*W-1]};
    q = (t >= {1'b0, d});
    if (q) t = t - {1'b0, d};
    return {t, p[2*W-2:0], q};
  endfunction

  assign in_ready = (state_q == IDLE) && (!ov_q || out_ready);
  assign accept   = in_valid && in_ready;
  assign st       = step(rem_q, prod_q, rt_q);
  assign st0      = step('0, {rs, {W{1'b0}}}, rt);

  always_comb begin
    sc    = '0;
    sc.op = opcode;
    unique case (opcode)
      OP_NOP: ;
      OP_LV:  begin sc.alu = rsi;     sc.rd_out = rd; sc.we = 1'b1; end
      OP_MLT: begin sc.alu = rs * rt; sc.rd_out = rd; sc.we = 1'b1; end
      OP_SUB: begin sc.alu = rs - rt; sc.rd_out = rd; sc.we = 1'b1; end
      OP_ADD: begin sc.alu = rs + rt; sc.rd_out = rd; sc.we = 1'b1; end
      OP_CP:  begin sc.mres = rsi; sc.rd_mem = rd; sc.mw = 1'b1; end
      OP_B:   sc.br = rd;
      OP_BEG: sc.br = (rd >= rs) ? rt : '0;
      OP_SLL: begin
        sc.alu    = (rt >= WV) ? '0 : rs << rt[SW-1:0];
        sc.rd_out = rd;
        sc.we     = 1'b1;
      end
      OP_GP:  begin sc.mout = rs; sc.rd_mem = rd; sc.mr = 1'b1; end
      OP_DIV, OP_DEC: ;
      default: sc.err = 1'b1;
    endcase
  end

  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    ov_d    = ov_q && !out_ready;
    opc_d   = opc_q;
    rd_d    = rd_q;
    rt_d    = rt_q;
    exp_d   = exp_q;
    base_d  = base_q;
    acc_d   = acc_q;
    prod_d  = prod_q;
    rem_d   = rem_q;
    cnt_d   = cnt_q;
    k_d     = k_q;
    dz_d    = dz_q;
    unique case (state_q)
      IDLE: if (accept) begin
        opc_d = opcode;
        rd_d  = rd;
        rt_d  = rt;
        exp_d = rsi[EXP_BITS-1:0];
        if (opcode == OP_DIV) begin
          rem_d   = st0[3*W:2*W];
          prod_d  = st0[2*W-1:0];
          cnt_d   = CDIV;
          dz_d    = (rt == '0);
          state_d = DIV_RUN;
        end else if (opcode == OP_DEC && rt == '0) begin
          out_d     = '0;
          out_d.op  = OP_DEC;
          out_d.err = 1'b1;
          ov_d      = 1'b1;
        end else if (opcode == OP_DEC) begin
          // Accept cycle doubles as the product phase of base = rs mod rt.
          prod_d  = {{W{1'b0}}, rs};
          rem_d   = '0;
          cnt_d   = CRED;
          k_d     = '0;
          acc_d   = {{(W-1){1'b0}}, rt != W'(1)};
          state_d = MM_RED;
        end else begin
          out_d = sc;
          ov_d  = 1'b1;
        end
      end
      DIV_RUN: begin
        rem_d  = st[3*W:2*W];
        prod_d = st[2*W-1:0];
        cnt_d  = cnt_q - 1'b1;
        if (cnt_q == '0) state_d = DONE;
      end
      MM_MUL: begin
        prod_d = k_q[0] ? {{W{1'b0}}, acc_q}  * {{W{1'b0}}, base_q}
                        : {{W{1'b0}}, base_q} * {{W{1'b0}}, base_q};
        rem_d   = '0;
        cnt_d   = CRED;
        state_d = MM_RED;
      end
      MM_RED: begin
        rem_d  = st[3*W:2*W];
        prod_d = st[2*W-1:0];
        cnt_d  = cnt_q - 1'b1;
        if (cnt_q == '0) begin
          if (k_q == '0) begin
            base_d = st[3*W-1:2*W];
          end else if (k_q[0]) begin
            if (exp_q[0]) acc_d = st[3*W-1:2*W];
          end else begin
            base_d = st[3*W-1:2*W];
            exp_d  = exp_q >> 1;
          end
          if (k_q == KLAST) begin
            state_d = DONE;
          end else begin
            k_d     = k_q + 1'b1;
            state_d = MM_MUL;
          end
        end
      end
      DONE: begin
        out_d        = '0;
        out_d.op     = opc_q;
        out_d.rd_out = rd_q;
        out_d.we     = 1'b1;
        out_d.alu    = (opc_q == OP_DIV) ? prod_q[W-1:0] : acc_q;
        out_d.err    = (opc_q == OP_DIV) && dz_q;
        ov_d         = 1'b1;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      out_q   <= '0;
      ov_q    <= 1'b0;
      opc_q   <= '0;
      rd_q    <= '0;
      rt_q    <= '0;
      exp_q   <= '0;
      base_q  <= '0;
      acc_q   <= '0;
      prod_q  <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
      k_q     <= '0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      ov_q    <= ov_d;
      opc_q   <= opc_d;
      rd_q    <= rd_d;
      rt_q    <= rt_d;
      exp_q   <= exp_d;
      base_q  <= base_d;
      acc_q   <= acc_d;
      prod_q  <= prod_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
      k_q     <= k_d;
      dz_q    <= dz_d;
    end
  end

  assign out_valid     = ov_q;
  assign op_out        = out_q.op;
  assign rd_out        = out_q.rd_out;
  assign rd_mem        = out_q.rd_mem;
  assign alu_result    = out_q.alu;
  assign mem_result    = out_q.mres;
  assign mem_out       = out_q.mout;
  assign branch_result = out_q.br;
  assign wr_enable     = out_q.we;
  assign mem_wr        = out_q.mw;
  assign mem_rd        = out_q.mr;
  assign err           = out_q.err;

endmodule
